// File: rtl/ps4_priority_selector.sv
// ps4_priority_selector: 4-input fixed-priority selector (bit 3 highest).
//
// The grant is combinational from req and en. A registered copy of the grant
// is also provided. With the PS4_STATS_EN macro defined, one saturating 8-bit
// counter per request line counts the clock edges on which that line was
// granted.
//
// Ports:
//   clock      in   1   system clock, rising-edge
//   reset      in   1   asynchronous active-high reset
//   req        in   4   request vector, bit 3 highest priority
//   en         in   1   global enable; 0 suppresses every grant
//   gnt        out  4   one-hot or zero grant, combinational
//   gnt_valid  out  1   OR of gnt, combinational
//   gnt_idx    out  2   binary index of the granted bit, 0 when none
//   gnt_q      out  4   gnt registered on clock
//   gnt_cnt    out  32  {cnt3,cnt2,cnt1,cnt0}, saturating at 255
//                       (present only with PS4_STATS_EN)
//
// Configuration macro: PS4_STATS_EN (undefined by default; statistics off).

module ps4_priority_selector (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic        en,
  output logic [3:0]  gnt,
  output logic        gnt_valid,
  output logic [1:0]  gnt_idx,
`ifdef PS4_STATS_EN
  output logic [3:0]  gnt_q,
  output logic [31:0] gnt_cnt
`else
  output logic [3:0]  gnt_q
`endif
);

  // Fixed-priority grant; each lower bit is masked by all higher requests.
  always_comb begin
    gnt    = 4'b0000;
    gnt[3] = en & req[3];
    gnt[2] = en & req[2] & ~req[3];
    gnt[1] = en & req[1] & ~req[2] & ~req[3];
    gnt[0] = en & req[0] & ~req[1] & ~req[2] & ~req[3];
  end

  assign gnt_valid = |gnt;

  always_comb begin
    gnt_idx = 2'd0;
    unique case (gnt)
      4'b1000: gnt_idx = 2'd3;
      4'b0100: gnt_idx = 2'd2;
      4'b0010: gnt_idx = 2'd1;
      4'b0001: gnt_idx = 2'd0;
      default: gnt_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q <= 4'b0000;
    end else begin
      gnt_q <= gnt;
    end
  end

`ifdef PS4_STATS_EN
  logic [7:0] cnt [4];

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt[i] <= 8'd0;
      end else if (gnt[i] && (cnt[i] != 8'hff)) begin
        cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  assign gnt_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_ps4_priority_selector.sv
module tb_ps4_priority_selector;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic        en;
  logic [3:0]  gnt;
  logic        gnt_valid;
  logic [1:0]  gnt_idx;
  logic [3:0]  gnt_q;
`ifdef PS4_STATS_EN
  logic [31:0] gnt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ps4_priority_selector dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .en        (en),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
`ifdef PS4_STATS_EN
    .gnt_q     (gnt_q),
    .gnt_cnt   (gnt_cnt)
`else
    .gnt_q     (gnt_q)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan from the highest bit down and grant the first request.
  function automatic logic [3:0] model_gnt(input logic e, input logic [3:0] r);
    logic [3:0] g;
    logic       found;
    g     = 4'b0000;
    found = 1'b0;
    for (int b = 3; b >= 0; b--) begin
      if (e && r[b] && !found) begin
        g[b]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [1:0] model_idx(input logic [3:0] g);
    logic [1:0] ix;
    ix = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (g[b]) ix = 2'(b);
    end
    return ix;
  endfunction

  logic [3:0] v_req [5];
  logic [3:0] v_gnt [5];
  logic [1:0] v_idx [5];
  logic       v_val [5];
  logic [3:0] w_req [4];
  logic [3:0] w_gnt [4];
  logic [3:0] eg;

  initial begin
    v_req = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    v_gnt = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    v_idx = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    v_val = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    w_req = '{4'b0101, 4'b0110, 4'b1110, 4'b1111};
    w_gnt = '{4'b0100, 4'b0100, 4'b1000, 4'b1000};

    // Reset state, with a request pending to show gnt works during reset.
    reset = 1'b1;
    en    = 1'b1;
    req   = 4'b0100;
    #2;
    check("reset_gnt_q", 32'(gnt_q), 32'h0);
    check("reset_gnt_live", 32'(gnt), 32'h4);
    @(posedge clock);
    #1;
    check("reset_gnt_q_held", 32'(gnt_q), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // One-hot requests, each also checked through the register.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      en  = 1'b1;
      req = v_req[i];
      #1;
      check($sformatf("single_gnt[%0d]", i), 32'(gnt), 32'(v_gnt[i]));
      check($sformatf("single_idx[%0d]", i), 32'(gnt_idx), 32'(v_idx[i]));
      check($sformatf("single_valid[%0d]", i), 32'(gnt_valid), 32'(v_val[i]));
      @(posedge clock);
      #1;
      check($sformatf("single_gnt_q[%0d]", i), 32'(gnt_q), 32'(v_gnt[i]));
    end

    // Multiple simultaneous requests.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      req = w_req[i];
      #1;
      check($sformatf("multi_gnt[%0d]", i), 32'(gnt), 32'(w_gnt[i]));
    end

    // Enable gating.
    @(negedge clock);
    req = 4'b1111;
    en  = 1'b1;
    #1;
    check("en1_gnt", 32'(gnt), 32'h8);
    en = 1'b0;
    #1;
    check("en0_gnt", 32'(gnt), 32'h0);
    check("en0_valid", 32'(gnt_valid), 32'h0);
    req = 4'b0110;
    #1;
    check("en0_req0110_gnt", 32'(gnt), 32'h0);
    check("en0_req0110_valid", 32'(gnt_valid), 32'h0);
    @(posedge clock);
    #1;
    check("en0_gnt_q", 32'(gnt_q), 32'h0);

    // Exhaustive {en,req} sweep, checked in the same time step.
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      en  = k[4];
      req = k[3:0];
      #1;
      eg = model_gnt(en, req);
      check($sformatf("sweep_gnt[%0d]", k), 32'(gnt), 32'(eg));
      check($sformatf("sweep_idx[%0d]", k), 32'(gnt_idx), 32'(model_idx(eg)));
      check($sformatf("sweep_valid[%0d]", k), 32'(gnt_valid), 32'(|eg));
    end

    // Asynchronous reset mid-cycle.
    @(negedge clock);
    en  = 1'b1;
    req = 4'b0010;
    @(posedge clock);
    #1;
    check("arst_pre_gnt_q", 32'(gnt_q), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_gnt_q_immediate", 32'(gnt_q), 32'h0);
    check("arst_gnt_live", 32'(gnt), 32'h2);
    check("arst_idx_live", 32'(gnt_idx), 32'h1);
    check("arst_valid_live", 32'(gnt_valid), 32'h1);
    @(posedge clock);
    #1;
    check("arst_gnt_q_held", 32'(gnt_q), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("arst_release_before_edge", 32'(gnt_q), 32'h0);
    @(posedge clock);
    #1;
    check("arst_release_gnt_q", 32'(gnt_q), 32'h2);

`ifdef PS4_STATS_EN
    // Saturating counters.
    @(negedge clock);
    reset = 1'b1;
    en    = 1'b1;
    req   = 4'b0001;
    #1;
    check("stats_reset_cnt", gnt_cnt, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("stats_cnt0_10", gnt_cnt, 32'h0000_000a);
    repeat (290) @(posedge clock);
    #1;
    check("stats_cnt0_sat", gnt_cnt, 32'h0000_00ff);
    repeat (5) @(posedge clock);
    #1;
    check("stats_cnt0_hold", gnt_cnt, 32'h0000_00ff);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps4_priority_selector.md
PS4_PRIORITY_SELECTOR -- requirements
Module: ps4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clock rising-edge, reset asserted high clears all state immediately without waiting for a clock edge.
REQ-002 Port: clock  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: req  input  4  request vector; bit 3 highest priority, bit 0 lowest.
REQ-005 Port: en  input  1  global enable; when 0, no grant is issued.
REQ-006 Port: gnt  output  4  one-hot or zero grant vector, combinational.
REQ-007 Port: gnt_valid  output  1  OR of gnt, combinational.
REQ-008 Port: gnt_idx  output  2  binary index of the granted bit, combinational; 0 when gnt_valid=0.
REQ-009 Port: gnt_q  output  4  gnt registered on clock.
REQ-010 Port: gnt_cnt  output  32  four 8-bit grant counters packed {cnt3,cnt2,cnt1,cnt0}; present only with PS4_STATS_EN.

Function
REQ-011 gnt[3] SHALL equal en & req[3].
REQ-012 gnt[2] SHALL equal en & req[2] & ~req[3].
REQ-013 gnt[1] SHALL equal en & req[1] & ~req[2] & ~req[3].
REQ-014 gnt[0] SHALL equal en & req[0] & ~req[1] & ~req[2] & ~req[3].
REQ-015 gnt SHALL be purely combinational from req and en: no clock latency, and independent of clock and reset.
REQ-016 gnt SHALL have at most one bit set; with req=0000 or en=0 it SHALL be 0000.
REQ-017 gnt_idx SHALL be 3,2,1,0 for gnt 1000,0100,0010,0001 respectively.
REQ-018 gnt_q SHALL load gnt on every rising clock edge when reset is low, giving one-cycle latency.
REQ-019 gnt_q SHALL be 0000 while reset is high.
REQ-020 Inputs that are X or Z are out of scope; for 0/1 inputs, outputs SHALL never be X.

Reset
REQ-021 On reset assertion, gnt_q SHALL become 0000 and, if present, all gnt_cnt counters SHALL become 0, immediately and asynchronously.
REQ-022 Combinational outputs (gnt, gnt_valid, gnt_idx) SHALL remain functional during reset.
REQ-023 Reset deassertion SHALL take effect at the next rising clock edge; no extra recovery cycles.

Configuration
REQ-024 Macro PS4_STATS_EN SHALL control the grant-statistics feature.
REQ-025 With PS4_STATS_EN defined, gnt_cnt SHALL exist: counter i increments by 1 on each rising edge where gnt[i]=1, saturates at 255 and holds there.
REQ-026 Without PS4_STATS_EN, the gnt_cnt port and its counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 en=1, req=0000 then 1000, 0100, 0010, 0001 -> gnt 0000, 1000, 0100, 0010, 0001; gnt_idx 0,3,2,1,0; gnt_valid 0,1,1,1,1.
REQ-028 en=1, req=0101, 0110, 1110, 1111 -> gnt 0100, 0100, 1000, 1000.
REQ-029 req=1111, en toggled 1->0, then req=0110 with en=0 -> gnt 0000 throughout en=0; gnt_valid=0.
REQ-030 Exhaustive sweep: all 32 {en,req} combinations -> gnt matches REQ-011..014 within the same time step.
REQ-031 en=1, req=0010 steady, clock running, reset pulsed high mid-cycle -> gnt_q clears at once without waiting for a clock edge; gnt stays 0010; after reset falls, gnt_q=0010 at the next edge.
REQ-032 (PS4_STATS_EN) en=1, req=0001 held for 300 cycles after reset -> cnt0 reaches 255 and holds; cnt1..cnt3 stay 0.
